// File: rtl/ws2812_multi_driver_if.sv
// Byte-write / show / status bundle between the I2C register decoder and the
// WS2812 frame driver.
interface ws2812_multi_driver_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 7
);
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic                show;
  logic                busy;
  logic [CHANNELS-1:0] led_o;

  modport master (
    output wr_en, wr_addr, wr_data, show,
    input  busy, led_o
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, show,
    output busy, led_o
  );
endinterface

// File: rtl/ws2812_multi_driver.sv
// Multi-channel WS2812 frame driver: byte-addressed frame buffer, lock-step serialisation of all
// channels, then a low latch gap. Optional global brightness scaling under `WS2812_BRIGHTNESS_EN.
module ws2812_multi_driver #(
  parameter int CHANNELS = 2,
  parameter int LED_CNT  = 11,
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 8,
  parameter int BIT_CYC  = 13,
  parameter int RES_CYC  = 500
) (
  input  logic clk,
  input  logic rst_n,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  ws2812_multi_driver_if.slave bus
);
  localparam int NBYTES = CHANNELS * LED_CNT * 3;
  localparam int ADDR_W = $clog2(NBYTES);
  localparam int KMAX   = LED_CNT * 3 - 1;
  localparam int K_W    = $clog2(LED_CNT * 3);
  localparam int CYC_W  = $clog2(BIT_CYC);
  localparam int RES_W  = (RES_CYC > 1) ? $clog2(RES_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d, fk;
  logic [2:0]                bit_q, bit_d;
  logic [CYC_W-1:0]          cyc_q, cyc_d;
  logic [RES_W-1:0]          res_q, res_d;
  logic [CHANNELS-1:0][7:0]  sh_q, sh_d, pre;
  logic [CHANNELS-1:0]       led_q, led_d;
  logic [7:0]                mem_q [NBYTES];
  logic                      wr_ok;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] br_q;

  // (byte * (br + 1)) >> 8: 255 passes the byte through, 0 blanks it
  function automatic logic [7:0] scale(input logic [7:0] b, input logic [7:0] br);
    logic [16:0] p;
    p = 17'(b) * 17'({1'b0, br} + 9'd1);
    return p[15:8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) br_q <= 8'd0;
    else if (state_q == IDLE && bus.show) br_q <= brightness;
  end
`endif

  assign wr_ok     = bus.wr_en && (state_q == IDLE) && (32'(bus.wr_addr) < NBYTES);
  assign bus.busy  = (state_q != IDLE);
  assign bus.led_o = led_q;

  // In SEND the next byte is prefetched so the LOAD cycle is hidden between bytes
  always_comb begin
    fk = k_q;
    if (state_q == SEND && k_q != K_W'(KMAX)) fk = k_q + K_W'(1);
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef WS2812_BRIGHTNESS_EN
      pre[c] = scale(mem_q[ADDR_W'(c * LED_CNT * 3) + ADDR_W'(fk)], br_q);
`else
      pre[c] = mem_q[ADDR_W'(c * LED_CNT * 3) + ADDR_W'(fk)];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: if (bus.show) state_d = LOAD;
      LOAD: begin
        sh_d    = pre;
        bit_d   = 3'd7;
        cyc_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
          cyc_d = '0;
          if (bit_q == 3'd0) begin
            if (k_q == K_W'(KMAX)) begin
              state_d = LATCH;
              res_d   = '0;
            end else begin
              k_d   = k_q + K_W'(1);
              sh_d  = pre;
              bit_d = 3'd7;
            end
          end else begin
            bit_d = bit_q - 3'd1;
            for (int c = 0; c < CHANNELS; c++) sh_d[c] = sh_q[c] << 1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      LATCH: begin
        if (res_q == RES_W'(RES_CYC - 1)) begin
          state_d = IDLE;
          res_d   = '0;
          k_d     = '0;
        end else begin
          res_d = res_q + RES_W'(1);
        end
      end
    endcase
    // Output is derived from next state so the registered line is aligned to the cell
    for (int c = 0; c < CHANNELS; c++)
      led_d[c] = (state_d == SEND) &&
                 (cyc_d < (sh_d[c][7] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      sh_q    <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      sh_q    <= sh_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES; i++) mem_q[i] <= 8'd0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Bench for ws2812_multi_driver: table of frame images plus hand sequences; a cell monitor
// compares every serialised bit cell against a scoreboard queue filled when show is accepted.
module tb_ws2812_multi_driver;
  localparam int CH    = 2;
  localparam int LEDS  = 2;
  localparam int T0H   = 4;
  localparam int T1H   = 8;
  localparam int BITC  = 13;
  localparam int RES   = 500;
  localparam int NB    = CH * LEDS * 3;
  localparam int AW    = $clog2(NB);
  localparam int CELLS = LEDS * 24;
  localparam int FRAME_LEN = 1 + CELLS * BITC + RES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] brightness = 8'hFF;
  logic [7:0] br_model = 8'hFF;
`endif

  ws2812_multi_driver_if #(.CHANNELS(CH), .ADDR_W(AW)) bus ();

  ws2812_multi_driver #(
    .CHANNELS(CH), .LED_CNT(LEDS), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .BIT_CYC(BITC), .RES_CYC(RES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model [NB];
  logic [CH-1:0] exp_q [$];
  int exp_len = FRAME_LEN;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] sent(input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_EN
    return 8'((int'(b) * (int'(br_model) + 1)) >> 8);
`else
    return b;
`endif
  endfunction

  task automatic push_frame();
    logic [7:0] byt;
    logic [CH-1:0] e;
    for (int k = 0; k < LEDS * 3; k++)
      for (int bi = 7; bi >= 0; bi--) begin
        for (int c = 0; c < CH; c++) begin
          byt  = sent(model[c * LEDS * 3 + k]);
          e[c] = byt[bi];
        end
        exp_q.push_back(e);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    if (!bus.busy && a < NB) model[a] = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic show_frame(input bit with_wr, input int a, input logic [7:0] d);
    if (with_wr) begin
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      if (!bus.busy && a < NB) model[a] = d;
    end
    bus.show = 1'b1;
    if (!bus.busy) begin
`ifdef WS2812_BRIGHTNESS_EN
      br_model = brightness;
`endif
      push_frame();
    end
    tick();
    bus.show  = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < FRAME_LEN + 50) begin
      tick();
      n++;
    end
    check("frame_ends", int'(bus.busy), 0);
    tick();
  endtask

  // Cell monitor: t=0 is the first busy cycle, cells follow back-to-back, then the latch gap
  int t = 0;
  logic busy_prev = 1'b0;
  logic latch_hi = 1'b0;
  logic [BITC-1:0] pat [CH];
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      t = 0;
      latch_hi = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.busy) begin
        if (!busy_prev) begin
          t = 0;
          latch_hi = 1'b0;
        end else begin
          t++;
        end
        if (t == 0 || t > CELLS * BITC) begin
          if (bus.led_o != '0) latch_hi = 1'b1;
        end else begin
          int ph;
          ph = (t - 1) % BITC;
          for (int c = 0; c < CH; c++) pat[c][ph] = bus.led_o[c];
          if (ph == BITC - 1) begin
            if (exp_q.size() == 0) begin
              check("cell_expected_available", 0, 1);
            end else begin
              logic [CH-1:0] e;
              e = exp_q.pop_front();
              for (int c = 0; c < CH; c++)
                check($sformatf("cell%0d_ch%0d_pattern", (t - 1) / BITC, c), int'(pat[c]),
                      (1 << (e[c] ? T1H : T0H)) - 1);
            end
          end
        end
      end else if (busy_prev) begin
        check("busy_length", t + 1, exp_len);
        check("led_low_outside_cells", int'(latch_hi), 0);
        check("scoreboard_drained", exp_q.size(), 0);
      end
      busy_prev = bus.busy;
    end
  end

  typedef struct {
    logic [7:0] bytes [NB];
    int         busy_len;
  } vec_t;
  vec_t vecs [5];

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.show = 1'b0;
    for (int i = 0; i < NB; i++) model[i] = 8'h00;

    for (int v = 0; v < 5; v++) begin
      vecs[v].busy_len = FRAME_LEN;
      for (int i = 0; i < NB; i++) vecs[v].bytes[i] = 8'h00;
    end
    vecs[0].bytes[0] = 8'h80; vecs[0].bytes[1] = 8'h00; vecs[0].bytes[2] = 8'h01;
    for (int i = 0; i < NB; i++) vecs[1].bytes[i] = 8'h3C;
    vecs[1].bytes[0] = 8'hFF; vecs[1].bytes[LEDS * 3] = 8'h00;
    for (int i = 0; i < NB; i++) vecs[2].bytes[i] = 8'hFF;
    for (int i = 0; i < NB; i++) vecs[3].bytes[i] = 8'(i * 37 + 5);
    for (int i = 0; i < NB; i++) vecs[4].bytes[i] = 8'($urandom_range(0, 255));

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_led", int'(bus.led_o), 0);

    // Frame timing: busy the cycle after show, line high the cycle after that
    write_byte(0, 8'hFF);
    write_byte(LEDS * 3, 8'hFF);
    show_frame(1'b0, 0, 8'h00);
    check("busy_after_show", int'(bus.busy), 1);
    check("led_low_in_load", int'(bus.led_o), 0);
    tick();
    check("led_rises_n_plus_2", int'(bus.led_o), (1 << CH) - 1);
    wait_idle();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NB; i++) write_byte(i, vecs[v].bytes[i]);
      exp_len = vecs[v].busy_len;
      show_frame(1'b0, 0, 8'h00);
      wait_idle();
    end

    // Write and show while busy are dropped; out-of-range addresses are ignored
    exp_len = FRAME_LEN;
    show_frame(1'b0, 0, 8'h00);
    repeat (100) tick();
    write_byte(0, 8'h55);
    show_frame(1'b0, 0, 8'h00);
    wait_idle();
    write_byte(NB, 8'hEE);
    write_byte((1 << AW) - 1, 8'hEE);
    show_frame(1'b0, 0, 8'h00);
    wait_idle();

    // Write landing in the same cycle as show is part of the frame
    show_frame(1'b1, 3, 8'hC3);
    wait_idle();

    // Asynchronous reset mid-frame, then a frame of all-zero bits
    show_frame(1'b0, 0, 8'h00);
    repeat (200) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_busy", int'(bus.busy), 0);
    check("midframe_reset_led", int'(bus.led_o), 0);
    for (int i = 0; i < NB; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    show_frame(1'b0, 0, 8'h00);
    wait_idle();

`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'h7F;
    write_byte(0, 8'hFF);
    show_frame(1'b0, 0, 8'h00);
    repeat (50) tick();
    brightness = 8'h10;
    wait_idle();
    brightness = 8'h00;
    show_frame(1'b0, 0, 8'h00);
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
